irq_dispatch: RTL and testbench

Core-side consumer of the interrupt controller's queued IRQ code stream. It captures each 3-bit code presented by the controller and drives `eirq` to request the next one. At an instruction boundary it redirects the core to a per-level vector, saves the return PC and previous level on a small stack, and restores both on return-from-interrupt. It sits between the interrupt controller and the `core` program-counter logic.

---
 rtl/irq_dispatch.sv | 194 +++++++++++++++++++
 tb/tb_irq_dispatch.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/irq_dispatch.sv
// ---------------------------------------------------------------------------
// irq_dispatch
//
// Core-side consumer of the interrupt controller's queued IRQ code stream.
// Holds one pending 3-bit code and raises eirq when the slot is free. At an
// instruction boundary it redirects the core to a per-level vector and pushes
// {return PC, previous level} onto a small return stack. On return-from-
// interrupt it pops the stack and restores both.
//
// Build option:
//   IRQ_NEST_EN  defined   -> a higher-level code preempts a running handler;
//                             the return stack holds DEPTH entries.
//                undefined -> dispatch only from thread mode (level 0);
//                             the return stack holds a single entry.
//
// Parameters:
//   DEPTH     return-stack entries (1..8)
//   VEC_BASE  word address of the level-1 vector; level n at +((n-1)<<2)
//
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   irq_in     code from controller (nonzero = one-cycle request)
//   eirq       registered; pending slot free, controller may pop next code
//   ie         global interrupt enable
//   step       core at an instruction boundary
//   pc         address of the next instruction
//   reti       one-cycle return-from-interrupt pulse
//   take       one-cycle pulse; core loads vector into PC
//   vector     vector address, valid while take
//   ret_valid  one-cycle pulse; core loads ret_pc into PC
//   ret_pc     restored PC, valid while ret_valid
//   level      current service level (0 = thread mode)
//   lost       sticky; code arrived while the pending slot was full
//   err        sticky; reti arrived with an empty stack
// ---------------------------------------------------------------------------
module irq_dispatch #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [14:0] VEC_BASE = 15'h0010
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  irq_in,
    output logic        eirq,
    input  logic        ie,
    input  logic        step,
    input  logic [14:0] pc,
    input  logic        reti,
    output logic        take,
    output logic [14:0] vector,
    output logic        ret_valid,
    output logic [14:0] ret_pc,
    output logic [2:0]  level,
    output logic        lost,
    output logic        err
);

    localparam int unsigned SP_W = $clog2(DEPTH + 1);

`ifdef IRQ_NEST_EN
    localparam int unsigned STK_DEPTH = DEPTH;
`else
    localparam int unsigned STK_DEPTH = 1;
`endif

    typedef enum logic [1:0] {
        S_IDLE,
        S_TAKE,
        S_RET
    } state_t;

    state_t      state_q, state_d;
    logic        pend_v_q, pend_v_d;
    logic [2:0]  pend_code_q, pend_code_d;
    logic        eirq_q, eirq_d;
    logic [14:0] vector_q, vector_d;
    logic [14:0] ret_pc_q, ret_pc_d;
    logic [2:0]  level_q, level_d;
    logic        lost_q, lost_d;
    logic        err_q, err_d;
    logic [SP_W-1:0] sp_q, sp_d;
    logic [14:0] pc_stk_q  [STK_DEPTH];
    logic [14:0] pc_stk_d  [STK_DEPTH];
    logic [2:0]  lvl_stk_q [STK_DEPTH];
    logic [2:0]  lvl_stk_d [STK_DEPTH];

    logic nest_ok;
    logic stk_full;
    logic can_dispatch;

    always_comb begin
        nest_ok = 1'b0;
`ifdef IRQ_NEST_EN
        nest_ok = (pend_code_q > level_q);
`endif
        stk_full     = (sp_q >= SP_W'(STK_DEPTH));
        can_dispatch = pend_v_q && ie && !stk_full &&
                       ((level_q == 3'd0) || nest_ok);
    end

    always_comb begin
        state_d     = S_IDLE;
        pend_v_d    = pend_v_q;
        pend_code_d = pend_code_q;
        vector_d    = vector_q;
        ret_pc_d    = ret_pc_q;
        level_d     = level_q;
        lost_d      = lost_q;
        err_d       = err_q;
        sp_d        = sp_q;
        pc_stk_d    = pc_stk_q;
        lvl_stk_d   = lvl_stk_q;

        // Capture and dispatch are mutually exclusive on pend_v_q, so a
        // code arriving in a dispatch cycle is counted as lost.
        if (irq_in != 3'd0) begin
            if (!pend_v_q) begin
                pend_v_d    = 1'b1;
                pend_code_d = irq_in;
            end else begin
                lost_d = 1'b1;
            end
        end

        // reti has priority; dispatch is only considered from IDLE.
        if (reti) begin
            if (sp_q != '0) begin
                sp_d = sp_q - 1'b1;
                for (int unsigned i = 0; i < STK_DEPTH; i++) begin
                    if (sp_q == SP_W'(i + 1)) begin
                        ret_pc_d = pc_stk_q[i];
                        level_d  = lvl_stk_q[i];
                    end
                end
                state_d = S_RET;
            end else begin
                err_d = 1'b1;
            end
        end else if (state_q == S_IDLE && step && can_dispatch) begin
            for (int unsigned i = 0; i < STK_DEPTH; i++) begin
                if (sp_q == SP_W'(i)) begin
                    pc_stk_d[i]  = pc;
                    lvl_stk_d[i] = level_q;
                end
            end
            sp_d     = sp_q + 1'b1;
            level_d  = pend_code_q;
            pend_v_d = 1'b0;
            vector_d = VEC_BASE + (15'({pend_code_q - 3'd1}) << 2);
            state_d  = S_TAKE;
        end

        eirq_d = ~pend_v_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            pend_v_q    <= 1'b0;
            pend_code_q <= '0;
            eirq_q      <= 1'b0;
            vector_q    <= '0;
            ret_pc_q    <= '0;
            level_q     <= '0;
            lost_q      <= 1'b0;
            err_q       <= 1'b0;
            sp_q        <= '0;
            pc_stk_q    <= '{default: '0};
            lvl_stk_q   <= '{default: '0};
        end else begin
            state_q     <= state_d;
            pend_v_q    <= pend_v_d;
            pend_code_q <= pend_code_d;
            eirq_q      <= eirq_d;
            vector_q    <= vector_d;
            ret_pc_q    <= ret_pc_d;
            level_q     <= level_d;
            lost_q      <= lost_d;
            err_q       <= err_d;
            sp_q        <= sp_d;
            pc_stk_q    <= pc_stk_d;
            lvl_stk_q   <= lvl_stk_d;
        end
    end

    assign eirq      = eirq_q;
    assign take      = (state_q == S_TAKE);
    assign vector    = vector_q;
    assign ret_valid = (state_q == S_RET);
    assign ret_pc    = ret_pc_q;
    assign level     = level_q;
    assign lost      = lost_q;
    assign err       = err_q;

endmodule

// File: tb/tb_irq_dispatch.sv
module tb_irq_dispatch;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  irq_in;
    logic        eirq;
    logic        ie;
    logic        step;
    logic [14:0] pc;
    logic        reti;
    logic        take;
    logic [14:0] vector;
    logic        ret_valid;
    logic [14:0] ret_pc;
    logic [2:0]  level;
    logic        lost;
    logic        err;

    irq_dispatch #(
        .DEPTH(4),
        .VEC_BASE(15'h0010)
    ) dut (
        .clk(clk), .rst(rst), .irq_in(irq_in), .eirq(eirq), .ie(ie),
        .step(step), .pc(pc), .reti(reti), .take(take), .vector(vector),
        .ret_valid(ret_valid), .ret_pc(ret_pc), .level(level),
        .lost(lost), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_ret;
        logic [14:0] addr;
        logic [2:0]  lvl;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_err    = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_take(input logic [14:0] v, input logic [2:0] l);
        sb.push_back('{is_ret: 1'b0, addr: v, lvl: l});
    endtask

    task automatic exp_ret(input logic [14:0] p, input logic [2:0] l);
        sb.push_back('{is_ret: 1'b1, addr: p, lvl: l});
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a pulse.
    always @(negedge clk) begin
        if (!rst) begin
            if (take && ret_valid) check("take_and_ret_together", 1, 0);
            if (take || ret_valid) begin
                if (sb.size() == 0) begin
                    check(take ? "unexpected_take" : "unexpected_ret", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("pulse_kind_is_ret", {31'd0, ret_valid}, {31'd0, e.is_ret});
                    if (take)
                        check("vector", {17'd0, vector}, {17'd0, e.addr});
                    else
                        check("ret_pc", {17'd0, ret_pc}, {17'd0, e.addr});
                    check("pulse_level", {29'd0, level}, {29'd0, e.lvl});
                end
            end
        end
    end

    initial begin
        rst = 1'b1; irq_in = 3'd5; ie = 1'b0; step = 1'b0; pc = '0; reti = 1'b0;
        tick(); tick();
        check("rst_eirq", {31'd0, eirq}, 0);
        check("rst_take", {31'd0, take}, 0);
        check("rst_vector", {17'd0, vector}, 0);
        check("rst_ret_valid", {31'd0, ret_valid}, 0);
        check("rst_ret_pc", {17'd0, ret_pc}, 0);
        check("rst_level", {29'd0, level}, 0);
        check("rst_lost", {31'd0, lost}, 0);
        check("rst_err", {31'd0, err}, 0);
        rst = 1'b0; irq_in = 3'd0;
        tick();
        check("eirq_after_reset", {31'd0, eirq}, 1);

        // Basic dispatch and return
        ie = 1'b1; irq_in = 3'd3;
        tick();
        irq_in = 3'd0;
        check("eirq_low_after_capture", {31'd0, eirq}, 0);
        step = 1'b1; pc = 15'h0123; exp_take(15'h0018, 3'd3);
        tick();
        step = 1'b0;
        tick();
        check("basic_level", {29'd0, level}, 3);
        check("basic_eirq_high", {31'd0, eirq}, 1);
        reti = 1'b1; exp_ret(15'h0123, 3'd0);
        tick();
        reti = 1'b0;
        tick();
        check("basic_level_back", {29'd0, level}, 0);
        check("basic_eirq_after_ret", {31'd0, eirq}, 1);

`ifdef IRQ_NEST_EN
        // Nesting
        irq_in = 3'd2; tick(); irq_in = 3'd0;
        step = 1'b1; pc = 15'h0100; exp_take(15'h0014, 3'd2); tick();
        step = 1'b0; tick();
        irq_in = 3'd5; tick(); irq_in = 3'd0;
        step = 1'b1; pc = 15'h0200; exp_take(15'h0020, 3'd5); tick();
        step = 1'b0; tick();
        irq_in = 3'd1; tick(); irq_in = 3'd0;
        step = 1'b1; tick(); tick(); step = 1'b0;
        check("nest_low_pending_eirq", {31'd0, eirq}, 0);
        check("nest_level5", {29'd0, level}, 5);
        reti = 1'b1; exp_ret(15'h0200, 3'd2); tick(); reti = 1'b0; tick();
        step = 1'b1; tick(); step = 1'b0;
        check("nest_level2_still", {29'd0, level}, 2);
        reti = 1'b1; exp_ret(15'h0100, 3'd0); tick(); reti = 1'b0; tick();
        step = 1'b1; pc = 15'h0300; exp_take(15'h0010, 3'd1); tick();
        step = 1'b0; tick();
        reti = 1'b1; exp_ret(15'h0300, 3'd0); tick(); reti = 1'b0; tick();
`else
        // No nesting: code 7 waits while in level 2
        irq_in = 3'd2; tick(); irq_in = 3'd0;
        step = 1'b1; pc = 15'h0050; exp_take(15'h0014, 3'd2); tick();
        step = 1'b0; tick();
        irq_in = 3'd7; tick(); irq_in = 3'd0;
        step = 1'b1; tick(); tick(); tick(); step = 1'b0;
        check("nonest_eirq_low", {31'd0, eirq}, 0);
        check("nonest_level2", {29'd0, level}, 2);
        reti = 1'b1; exp_ret(15'h0050, 3'd0); tick(); reti = 1'b0; tick();
        step = 1'b1; pc = 15'h0060; exp_take(15'h0028, 3'd7); tick();
        step = 1'b0; tick();
        reti = 1'b1; exp_ret(15'h0060, 3'd0); tick(); reti = 1'b0; tick();
`endif

        // Overflow with ie=0
        ie = 1'b0;
        irq_in = 3'd4; tick();
        irq_in = 3'd6; tick();
        irq_in = 3'd0;
        check("ovf_lost", {31'd0, lost}, 1);
        check("ovf_eirq", {31'd0, eirq}, 0);
        step = 1'b1; tick(); tick();
        ie = 1'b1; pc = 15'h0070; exp_take(15'h001C, 3'd4); tick();
        step = 1'b0; tick();
        check("ovf_lost_sticky", {31'd0, lost}, 1);
        reti = 1'b1; exp_ret(15'h0070, 3'd0); tick(); reti = 1'b0; tick();

        // Collision: reti beats step
        irq_in = 3'd1; tick(); irq_in = 3'd0;
        step = 1'b1; pc = 15'h0080; exp_take(15'h0010, 3'd1); tick();
        step = 1'b0; tick();
        irq_in = 3'd2; tick(); irq_in = 3'd0;
        step = 1'b1; reti = 1'b1; pc = 15'h0090; exp_ret(15'h0080, 3'd0); tick();
        step = 1'b0; reti = 1'b0; tick();
        step = 1'b1; pc = 15'h0080; exp_take(15'h0014, 3'd2); tick();
        step = 1'b0; tick();
        reti = 1'b1; exp_ret(15'h0080, 3'd0); tick(); reti = 1'b0; tick();

        // reti with empty stack
        check("err_before", {31'd0, err}, 0);
        reti = 1'b1; tick(); reti = 1'b0;
        check("err_set", {31'd0, err}, 1);
        check("err_level", {29'd0, level}, 0);
        tick();

        // Reset squashes a dispatch
        irq_in = 3'd3; tick(); irq_in = 3'd0;
        step = 1'b1; pc = 15'h0100; rst = 1'b1; tick();
        step = 1'b0; rst = 1'b0;
        check("rst2_take", {31'd0, take}, 0);
        check("rst2_eirq", {31'd0, eirq}, 0);
        check("rst2_lost", {31'd0, lost}, 0);
        check("rst2_err", {31'd0, err}, 0);
        check("rst2_level", {29'd0, level}, 0);
        check("rst2_vector", {17'd0, vector}, 0);
        check("rst2_ret_pc", {17'd0, ret_pc}, 0);
        tick();
        check("rst2_eirq_rise", {31'd0, eirq}, 1);
        check("rst2_take_after", {31'd0, take}, 0);
        step = 1'b1; tick(); tick(); step = 1'b0; tick();
        check("sb_empty", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
